// File: rtl/fir_sample_source_pkg.sv
// Shared definitions for the FIR sample source: default sample width and FSM states.
package fir_sample_source_pkg;

    localparam int unsigned FIR_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } src_state_t;

endpackage

// File: rtl/fir_src_mem.sv
// Sample storage for fir_sample_source: register array, gated write, combinational read.
module fir_src_mem
    import fir_sample_source_pkg::*;
#(
    parameter int unsigned DATA_W = FIR_DATA_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_sample_source.sv
// Programmable sample transmitter feeding the fir data_in/valid_in strobe interface.
// Define FIR_SRC_LOOP_EN to add the `loop` input for continuous replay.
module fir_sample_source
    import fir_sample_source_pkg::*;
#(
    parameter int unsigned DATA_W = FIR_DATA_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned GAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic [GAP_W-1:0]  gap,
    input  logic              start,
    input  logic              abort,
`ifdef FIR_SRC_LOOP_EN
    input  logic              loop,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    src_state_t        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] nxt_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   len_clamp;
    logic [GAP_W-1:0]  gap_r;
    logic [GAP_W-1:0]  gap_cnt;
    logic              last;
    logic              loop_req;
    logic              wr_accept;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rd_fwd;

`ifdef FIR_SRC_LOOP_EN
    assign loop_req = loop;
`else
    assign loop_req = 1'b0;
`endif

    assign wr_accept = wr_en && (state == IDLE);
    assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
    assign last      = ({1'b0, idx} == len_r - 1'b1);
    assign nxt_idx   = last ? '0 : idx + 1'b1;
    assign rd_addr   = (state == IDLE) ? '0 : nxt_idx;

    // A write landing in the start cycle must already be visible in the first sample.
    assign rd_fwd = (wr_accept && (wr_addr == rd_addr)) ? wr_data : rd_data;

    fir_src_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            len_r     <= '0;
            gap_r     <= '0;
            gap_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        len_r   <= len_clamp;
                        gap_r   <= gap;
                        idx     <= '0;
                        gap_cnt <= '0;
                        if (len_clamp != '0) begin
                            state     <= EMIT;
                            valid_out <= 1'b1;
                            data_out  <= rd_fwd;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (last && !loop_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_r == '0) begin
                        idx       <= nxt_idx;
                        valid_out <= 1'b1;
                        data_out  <= rd_fwd;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= gap_r;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        state     <= EMIT;
                        idx       <= nxt_idx;
                        gap_cnt   <= '0;
                        valid_out <= 1'b1;
                        data_out  <= rd_fwd;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
